// File: rtl/noise_pkg.sv
// noise_pkg: shared FSM states, default LFSR constants and the LFSR step function.
package noise_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GEN = 2'd1, DONE = 2'd2} noise_state_t;
  localparam int DEF_LFSR_W = 3;
  localparam logic [DEF_LFSR_W-1:0] DEF_TAPS = 3'b110;
  localparam logic [DEF_LFSR_W-1:0] DEF_SEED = 3'b001;
  // Widths up to 32; callers truncate back to their own width.
  function automatic logic [31:0] lfsr_step(input logic [31:0] lfsr, input logic [31:0] taps);
    return {lfsr[30:0], ^(lfsr & taps)};
  endfunction
endpackage

// File: rtl/noise_lfsr.sv
// noise_lfsr: Fibonacci LFSR register with synchronous load, step enable and zero-seed substitution.
module noise_lfsr
  import noise_pkg::*;
#(
  parameter int W = DEF_LFSR_W,
  parameter logic [W-1:0] TAPS = DEF_TAPS,
  parameter logic [W-1:0] SEED = DEF_SEED
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  output logic [W-1:0] state,
  output logic         zero_seed
);
  assign zero_seed = load && load_val == '0;
  always_ff @(posedge clock)
    if (!reset_n) state <= SEED;
    else if (load) state <= zero_seed ? SEED : load_val;
    else if (step) state <= W'(lfsr_step(32'(state), 32'(TAPS)));
endmodule

// File: rtl/noise_word_arbiter.sv
// noise_word_arbiter: round-robin sharing of one LFSR noise source, one OUT_W-bit word per grant.
// Optional NOISE_ARB_STATS_EN adds a 16-bit word_count output.
module noise_word_arbiter
  import noise_pkg::*;
#(
  parameter int LFSR_W = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0] TAPS = DEF_TAPS,
  parameter logic [LFSR_W-1:0] SEED = DEF_SEED,
  parameter int NREQ = 2,
  parameter int OUT_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              seed_valid,
  input  logic [LFSR_W-1:0] seed,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   grant,
  output logic [OUT_W-1:0]  data,
  output logic              data_valid,
  output logic              busy,
  output logic              lockup
`ifdef NOISE_ARB_STATS_EN
  , output logic [15:0]     word_count
`endif
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = OUT_W > 1 ? $clog2(OUT_W) : 1;
  noise_state_t state;
  logic [IW-1:0] rr, winner, pick;
  logic [CW-1:0] cnt;
  logic [OUT_W-2:0] data_sr;
  logic [OUT_W-1:0] shifted;
  logic [LFSR_W-1:0] lfsr;
  logic zero_seed, last, lfsr_unused;
  assign last = cnt == CW'(OUT_W - 1);
  assign shifted = {data_sr, lfsr[LFSR_W-1]};
  assign lfsr_unused = ^lfsr[LFSR_W-2:0];
  noise_lfsr #(.W(LFSR_W), .TAPS(TAPS), .SEED(SEED)) u_lfsr (
    .clock(clock),
    .reset_n(reset_n),
    .load(state == IDLE && seed_valid),
    .load_val(seed),
    .step(state == GEN),
    .state(lfsr),
    .zero_seed(zero_seed)
  );
  // Descending scan so the lowest offset from rr wins.
  always_comb begin
    pick = rr;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[(int'(rr) + i) % NREQ]) pick = IW'((int'(rr) + i) % NREQ);
  end
  always_ff @(posedge clock)
    if (!reset_n) begin
      state <= IDLE;
      rr <= '0;
      winner <= '0;
      cnt <= '0;
      data_sr <= '0;
      data <= '0;
      grant <= '0;
      data_valid <= 1'b0;
      busy <= 1'b0;
      lockup <= 1'b0;
    end else begin
      if (zero_seed) lockup <= 1'b1;
      grant <= '0;
      data_valid <= 1'b0;
      case (state)
        IDLE:
          if (!seed_valid && |req) begin
            winner <= pick;
            cnt <= '0;
            busy <= 1'b1;
            state <= GEN;
          end
        GEN: begin
          data_sr <= shifted[OUT_W-2:0];
          cnt <= cnt + 1'b1;
          if (last) begin
            data <= shifted;
            data_valid <= 1'b1;
            grant <= NREQ'(1) << winner;
            state <= DONE;
          end
        end
        DONE: begin
          rr <= winner == IW'(NREQ - 1) ? '0 : winner + 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef NOISE_ARB_STATS_EN
  always_ff @(posedge clock)
    if (!reset_n) word_count <= '0;
    else if (data_valid) word_count <= word_count + 1'b1;
`endif
endmodule

// File: tb/tb_noise_word_arbiter.sv
// tb_noise_word_arbiter: directed checks of seeding, lockup, round-robin grants and word values.
module tb_noise_word_arbiter;
  logic clock, reset_n, seed_valid, data_valid, busy, lockup;
  logic [2:0] seed;
  logic [1:0] req, grant;
  logic [7:0] data;
  int checks = 0, failures = 0, words = 0;
`ifdef NOISE_ARB_STATS_EN
  logic [15:0] word_count;
`endif
  noise_word_arbiter dut (
    .clock(clock),
    .reset_n(reset_n),
    .seed_valid(seed_valid),
    .seed(seed),
    .req(req),
    .grant(grant),
    .data(data),
    .data_valid(data_valid),
    .busy(busy),
    .lockup(lockup)
`ifdef NOISE_ARB_STATS_EN
    , .word_count(word_count)
`endif
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    seed_valid = 1'b0;
    seed = '0;
    req = '0;
    tick();
    tick();
    reset_n = 1'b1;
    words = 0;
  endtask
  // Drive req, wait (bounded) for data_valid, check latency, word and grant.
  task automatic word(input logic [1:0] r, input logic [7:0] d, input logic [1:0] g, input int n, input string tag);
    int k;
    k = 0;
    req = r;
    do begin
      tick();
      k++;
    end while (!data_valid && k < 40);
    if (data_valid) words++;
    chk({tag, "_lat"}, k, n);
    chk({tag, "_data"}, data, d);
    chk({tag, "_grant"}, grant, g);
  endtask
  initial begin
    do_reset();
    reset_n = 1'b0;
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_data", data, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lockup", lockup, 0);
    chk("rst_lfsr", dut.u_lfsr.state, 3'b001);
    reset_n = 1'b1;
    tick();
    word(2'b01, 8'h2E, 2'b01, 9, "w1");
    chk("w1_busy", busy, 1);
    chk("w1_lfsr", dut.u_lfsr.state, 3'b010);
    req = 2'b00;
    tick();
    chk("w1_pulse_valid", data_valid, 0);
    chk("w1_pulse_grant", grant, 0);
    chk("w1_hold_data", data, 8'h2E);
    chk("w1_idle_busy", busy, 0);
    do_reset();
    word(2'b11, 8'h2E, 2'b01, 9, "rr0");
    word(2'b11, 8'h5C, 2'b10, 10, "rr1");
    word(2'b11, 8'hB9, 2'b01, 10, "rr2");
    word(2'b11, 8'h72, 2'b10, 10, "rr3");
    req = 2'b00;
    tick();
    chk("rr_lfsr", dut.u_lfsr.state, 3'b111);
    do_reset();
    seed_valid = 1'b1;
    seed = 3'b000;
    tick();
    seed_valid = 1'b0;
    chk("zs_lockup", lockup, 1);
    chk("zs_lfsr", dut.u_lfsr.state, 3'b001);
    word(2'b01, 8'h2E, 2'b01, 9, "zs");
    req = 2'b00;
    tick();
    seed_valid = 1'b1;
    seed = 3'b111;
    tick();
    seed_valid = 1'b0;
    chk("zs_sticky", lockup, 1);
    chk("zs_reseed", dut.u_lfsr.state, 3'b111);
    do_reset();
    chk("zs_cleared", lockup, 0);
    seed_valid = 1'b1;
    seed = 3'b111;
    req = 2'b01;
    tick();
    seed_valid = 1'b0;
    chk("sr_busy", busy, 0);
    chk("sr_lfsr", dut.u_lfsr.state, 3'b111);
    word(2'b01, 8'hE5, 2'b01, 9, "sr");
    chk("sr_end_lfsr", dut.u_lfsr.state, 3'b110);
    do_reset();
    req = 2'b01;
    tick();
    tick();
    tick();
    seed_valid = 1'b1;
    seed = 3'b000;
    tick();
    seed_valid = 1'b0;
    word(2'b01, 8'h2E, 2'b01, 5, "sg");
    chk("sg_lockup", lockup, 0);
    chk("sg_lfsr", dut.u_lfsr.state, 3'b010);
    do_reset();
    req = 2'b01;
    tick();
    chk("mr_busy", busy, 1);
    repeat (4) tick();
    reset_n = 1'b0;
    req = 2'b00;
    tick();
    chk("mr_grant", grant, 0);
    chk("mr_valid", data_valid, 0);
    chk("mr_data", data, 0);
    chk("mr_busy_low", busy, 0);
    chk("mr_lfsr", dut.u_lfsr.state, 3'b001);
    reset_n = 1'b1;
    repeat (10) tick();
    chk("mr_no_grant", grant, 0);
    chk("mr_no_valid", data_valid, 0);
    word(2'b01, 8'h2E, 2'b01, 9, "mr");
    req = 2'b00;
    tick();
`ifdef NOISE_ARB_STATS_EN
    chk("stats_count", word_count, words);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
